// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity constants and
// frame-format helpers used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Frame lengths outside 5..8 fall back to a full byte.
  function automatic logic [3:0] legal_length(input logic [3:0] len);
    return (len >= 4'd5 && len <= 4'd8) ? len : 4'd8;
  endfunction

  // Data arrives LSB-first into the MSB, so a short frame sits in the top bits.
  function automatic logic [7:0] align_data(input logic [7:0] shift, input logic [3:0] len);
    return shift >> (4'd8 - len);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous control lines; resets to the
// idle-high level so a UART line does not look like a start bit after reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
    end
  end

  assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: validates the start bit, recovers 5-8 data bits,
// checks optional parity and 1-2 stop bits, then pulses rx_done with the byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       rx_tick,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] frame_length,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  output logic [7:0] rx_dout,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  // The tick counter is cleared on the tick that starts a phase, so it reads
  // one less than the tick number within that phase.
  localparam logic [3:0] START_CHECK = 4'(OVERSAMPLE / 2 - 2);
  localparam logic [3:0] BIT_CENTRE  = 4'(OVERSAMPLE - 1);

  logic       rxs;
  rx_state_t  state_reg, state_next;
  logic [3:0] tick_cnt_reg;
  logic [3:0] bit_cnt_reg;
  logic [3:0] len_reg;
  logic [7:0] shift_reg;
  logic       parity_acc_reg;
  logic       parity_err_reg;
  logic       frame_err_reg;
  logic       par_en_reg;
  logic       par_type_reg;
  logic       stop2_reg;

  logic at_check, start_ok, sample, last_data, last_stop, finish, stop_bad;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (rx_tick),
    .reset(reset),
    .din  (rx),
    .dout (rxs)
  );

  always_ff @(posedge rx_tick or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!rxs) state_next = START;
      START:   if (at_check) state_next = rxs ? IDLE : DATA;
      DATA:    if (sample && last_data) state_next = par_en_reg ? PARITY : STOP;
      PARITY:  if (sample) state_next = STOP;
      STOP:    if (finish) state_next = stop_bad ? BREAK : IDLE;
      BREAK:   if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    at_check  = (state_reg == START) && (tick_cnt_reg == START_CHECK);
    start_ok  = at_check && !rxs;
    sample    = (state_reg == DATA || state_reg == PARITY || state_reg == STOP)
                && (tick_cnt_reg == BIT_CENTRE);
    last_data = (bit_cnt_reg == len_reg - 4'd1);
    last_stop = stop2_reg ? (bit_cnt_reg == 4'd1) : (bit_cnt_reg == 4'd0);
    finish    = sample && (state_reg == STOP) && last_stop;
    // Includes the stop sample being taken this cycle.
    stop_bad  = frame_err_reg || !rxs;
  end

  always_ff @(posedge rx_tick or posedge reset) begin
    if (reset) begin
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      len_reg        <= 4'd8;
      shift_reg      <= '0;
      parity_acc_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      par_en_reg     <= 1'b0;
      par_type_reg   <= PARITY_EVEN;
      stop2_reg      <= 1'b0;
    end else begin
      if (state_reg == IDLE || state_reg == BREAK || at_check || sample) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 4'd1;
      end

      // Frame format is frozen once the start bit is confirmed.
      if (start_ok) begin
        len_reg        <= legal_length(frame_length);
        par_en_reg     <= parity_en;
        par_type_reg   <= (parity_type == PARITY_ODD) ? PARITY_ODD : PARITY_EVEN;
        stop2_reg      <= stop2;
        bit_cnt_reg    <= '0;
        shift_reg      <= '0;
        parity_acc_reg <= 1'b0;
        parity_err_reg <= 1'b0;
        frame_err_reg  <= 1'b0;
      end

      if (sample) begin
        case (state_reg)
          DATA: begin
            shift_reg      <= {rxs, shift_reg[7:1]};
            parity_acc_reg <= parity_acc_reg ^ rxs;
            bit_cnt_reg    <= last_data ? 4'd0 : bit_cnt_reg + 4'd1;
          end
          PARITY: begin
            parity_err_reg <= (parity_acc_reg ^ rxs) != par_type_reg;
            bit_cnt_reg    <= '0;
          end
          STOP: begin
            if (!rxs) frame_err_reg <= 1'b1;
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rx_tick or posedge reset) begin
    if (reset) begin
      rx_done      <= 1'b0;
      rx_dout      <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= finish;
      if (finish) begin
        rx_dout      <= align_data(shift_reg, len_reg);
        parity_error <= par_en_reg & parity_err_reg;
        frame_error  <= stop_bad;
      end
    end
  end

endmodule
